// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl
// Round sequencer for the number-guessing game. Latches a target from the
// LFSR on start, grades up to MAX_TRIES guesses from the switches as big,
// small or equal, runs a per-round countdown and declares win or lose.
//
// Optional feature macro: GUESS_NARROW_EN
//   defined     -> lo_bound/hi_bound track the still-possible target range
//   not defined -> lo_bound=0, hi_bound=255 constantly, no bound registers
module guess_round_ctrl #(
    parameter int MAX_TRIES  = 7,         // guesses allowed per round (1..15)
    parameter int TICK_DIV   = 50000000,  // clk cycles per countdown second (>=2)
    parameter int TIME_LIMIT = 30         // seconds per round (1..255)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       guess_btn,
    input  logic [7:0] guess,
    input  logic [7:0] rand_in,
    output logic [7:0] target,
    output logic       big,
    output logic       smal,
    output logic       win,
    output logic       lose,
    output logic [3:0] tries,
    output logic [7:0] time_left,
    output logic       timer_run,
    output logic [2:0] state,
    output logic [7:0] lo_bound,
    output logic [7:0] hi_bound
);

    localparam int                TICK_W     = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
    localparam logic [3:0]        TRIES_MAX  = 4'(MAX_TRIES);
    localparam logic [7:0]        TIME_INIT  = 8'(TIME_LIMIT);
    localparam int                NBTN       = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning: index 0 = start, index 1 = guess.
    // A held button yields exactly one pulse; the pulse is registered so
    // the FSM acts three edges after the edge that first sees the press.
    // ------------------------------------------------------------------
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn_pulse;
    logic            start_p;
    logic            guess_p;

    assign btn_raw = {guess_btn, start_btn};

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            logic sync1_reg;
            logic sync2_reg;
            logic prev_reg;
            logic pulse_reg;

            // two-flop synchronizer followed by a registered rising-edge detect
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    prev_reg  <= 1'b0;
                    pulse_reg <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= sync2_reg;
                    pulse_reg <= sync2_reg & ~prev_reg;
                end
            end

            assign btn_pulse[gi] = pulse_reg;
        end
    endgenerate

    assign start_p = btn_pulse[0];
    assign guess_p = btn_pulse[1];

    // ------------------------------------------------------------------
    // Round state
    // ------------------------------------------------------------------
    state_t            state_reg;
    logic [7:0]        target_reg;
    logic [7:0]        guess_q_reg;
    logic              big_reg;
    logic              smal_reg;
    logic              win_reg;
    logic              lose_reg;
    logic [3:0]        tries_reg;
    logic [7:0]        time_left_reg;
    logic              timer_run_reg;
    logic [TICK_W-1:0] tick_reg;

    logic              guess_eq;
    logic              guess_gt;
    logic [3:0]        tries_inc;

    // unsigned 8-bit grading of the captured guess
    assign guess_eq  = (guess_q_reg == target_reg);
    assign guess_gt  = (guess_q_reg >  target_reg);
    // tries saturates at MAX_TRIES rather than wrapping
    assign tries_inc = (tries_reg >= TRIES_MAX) ? tries_reg : (tries_reg + 4'd1);

`ifdef GUESS_NARROW_EN
    logic [7:0] lo_bound_reg;
    logic [7:0] hi_bound_reg;
    logic [7:0] guess_dec;
    logic [7:0] guess_inc;

    // a big guess is >= 1 and a small guess is <= 254, so these never wrap
    // when they are actually used
    assign guess_dec = guess_q_reg - 8'd1;
    assign guess_inc = guess_q_reg + 8'd1;
`endif

    // round sequencer: one FSM holding every registered output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            target_reg    <= 8'd0;
            guess_q_reg   <= 8'd0;
            big_reg       <= 1'b0;
            smal_reg      <= 1'b0;
            win_reg       <= 1'b0;
            lose_reg      <= 1'b0;
            tries_reg     <= 4'd0;
            time_left_reg <= 8'd0;
            timer_run_reg <= 1'b0;
            tick_reg      <= '0;
`ifdef GUESS_NARROW_EN
            lo_bound_reg  <= 8'd0;
            hi_bound_reg  <= 8'hFF;
`endif
        end else begin
            case (state_reg)
                // idle and end-of-round states only react to start
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (start_p) begin
                        target_reg    <= rand_in;
                        tries_reg     <= 4'd0;
                        time_left_reg <= TIME_INIT;
                        big_reg       <= 1'b0;
                        smal_reg      <= 1'b0;
                        win_reg       <= 1'b0;
                        lose_reg      <= 1'b0;
                        tick_reg      <= '0;
                        timer_run_reg <= 1'b1;
                        state_reg     <= ST_PLAY;
`ifdef GUESS_NARROW_EN
                        lo_bound_reg  <= 8'd0;
                        hi_bound_reg  <= 8'hFF;
`endif
                    end
                end

                ST_PLAY: begin
                    if (time_left_reg == 8'd0) begin
                        // timeout takes priority over a guess in the same cycle
                        lose_reg      <= 1'b1;
                        timer_run_reg <= 1'b0;
                        state_reg     <= ST_LOSE;
                    end else begin
                        if (tick_reg == TICK_LAST) begin
                            tick_reg      <= '0;
                            time_left_reg <= time_left_reg - 8'd1;
                        end else begin
                            tick_reg <= tick_reg + TICK_ONE;
                        end
                        if (guess_p) begin
                            guess_q_reg   <= guess;
                            tries_reg     <= tries_inc;
                            timer_run_reg <= 1'b0;
                            state_reg     <= ST_CHECK;
                        end
                    end
                end

                // single grading cycle; the tick counter holds its value here
                ST_CHECK: begin
                    if (guess_eq) begin
                        big_reg   <= 1'b0;
                        smal_reg  <= 1'b0;
                        win_reg   <= 1'b1;
                        state_reg <= ST_WIN;
                    end else begin
                        big_reg  <= guess_gt;
                        smal_reg <= ~guess_gt;
`ifdef GUESS_NARROW_EN
                        if (guess_gt) begin
                            if (guess_dec < hi_bound_reg) begin
                                hi_bound_reg <= guess_dec;
                            end
                        end else begin
                            if (guess_inc > lo_bound_reg) begin
                                lo_bound_reg <= guess_inc;
                            end
                        end
`endif
                        if (tries_reg == TRIES_MAX) begin
                            lose_reg  <= 1'b1;
                            state_reg <= ST_LOSE;
                        end else begin
                            timer_run_reg <= 1'b1;
                            state_reg     <= ST_PLAY;
                        end
                    end
                end

                default: begin
                    timer_run_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign target    = target_reg;
    assign big       = big_reg;
    assign smal      = smal_reg;
    assign win       = win_reg;
    assign lose      = lose_reg;
    assign tries     = tries_reg;
    assign time_left = time_left_reg;
    assign timer_run = timer_run_reg;
    assign state     = state_reg;

`ifdef GUESS_NARROW_EN
    assign lo_bound  = lo_bound_reg;
    assign hi_bound  = hi_bound_reg;
`else
    assign lo_bound  = 8'd0;
    assign hi_bound  = 8'hFF;
`endif

endmodule
